// File: rtl/half_layer1_sequencer.sv
// half_layer1_sequencer: walks one fully-connected layer of half-precision
// neurons through a shared external MAC unit (op_c + op_a*op_b).
// Per neuron j: the accumulator is seeded with b[j], then one MAC is issued per
// input i (weight address i*LAYER2_NEURONS+j), and the result is written out.
// Optional build macro HALF_LAYER1_RELU_EN: ReLU (sign bit clears the value)
// is applied on the output write; otherwise the accumulator is written as-is.
module half_layer1_sequencer #(
    parameter int LAYER1_NEURONS = 784,
    parameter int LAYER2_NEURONS = 50,
    localparam int XW = (LAYER1_NEURONS > 1) ? $clog2(LAYER1_NEURONS) : 1,
    localparam int WW = (LAYER1_NEURONS * LAYER2_NEURONS > 1) ?
                        $clog2(LAYER1_NEURONS * LAYER2_NEURONS) : 1,
    localparam int BW = (LAYER2_NEURONS > 1) ? $clog2(LAYER2_NEURONS) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x_addr,
    output logic [WW-1:0] w_addr,
    output logic [BW-1:0] b_addr,
    input  logic [15:0]   x_data,
    input  logic [15:0]   w_data,
    input  logic [15:0]   b_data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [15:0]   op_a,
    output logic [15:0]   op_b,
    output logic [15:0]   op_c,
    input  logic          res_valid,
    input  logic [15:0]   res_data,
    output logic          l_wr_en,
    output logic [BW-1:0] l_wr_addr,
    output logic [15:0]   l_wr_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIAS   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   i_q, i_d;
    logic [BW-1:0]   j_q, j_d;
    logic [15:0]     acc_q, acc_d;
    logic [31:0]     w_lin;

    // Output activation applied on the write port only; acc itself is untouched.
    function automatic logic [15:0] act_f(input logic [15:0] v);
`ifdef HALF_LAYER1_RELU_EN
        // Any value with the sign bit set (including -0) becomes +0.
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    // Row-major weight address; products stay well inside 32 bits.
    assign w_lin = $unsigned(32'(i_q)) * $unsigned(32'(LAYER2_NEURONS)) + $unsigned(32'(j_q));

    // State, index counters and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic: one MAC outstanding at a time, counters never wrap.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = BIAS;
                end
            end
            BIAS: begin
                acc_d   = b_data;
                i_d     = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (op_ready) state_d = WAIT;
            end
            WAIT: begin
                if (res_valid) begin
                    acc_d = res_data;
                    if (i_q == XW'(LAYER1_NEURONS - 1)) begin
                        state_d = WRITE;
                    end else begin
                        i_d     = i_q + XW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            WRITE: begin
                if (j_q == BW'(LAYER2_NEURONS - 1)) begin
                    state_d = FINISH;
                end else begin
                    j_d     = j_q + BW'(1);
                    state_d = BIAS;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; everything is forced to zero while rstn is low.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_c      = '0;
        l_wr_en   = 1'b0;
        l_wr_addr = '0;
        l_wr_data = '0;
        x_addr    = '0;
        w_addr    = '0;
        b_addr    = '0;
        if (rstn) begin
            x_addr = i_q;
            w_addr = w_lin[WW-1:0];
            b_addr = j_q;
            busy   = (state_q != IDLE) && (state_q != FINISH);
            case (state_q)
                ISSUE: begin
                    op_valid = 1'b1;
                    op_a     = x_data;
                    op_b     = w_data;
                    op_c     = acc_q;
                end
                WRITE: begin
                    l_wr_en   = 1'b1;
                    l_wr_addr = j_q;
                    l_wr_data = act_f(acc_q);
                end
                FINISH:  done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/half_layer1_sequencer.md
HALF_LAYER1_SEQUENCER -- requirements
Module: half_layer1_sequencer

Interface
REQ-001 SHALL have parameter LAYER1_NEURONS, default 784, meaning the number of inputs summed per neuron.
REQ-002 SHALL have parameter LAYER2_NEURONS, default 50, meaning the number of output neurons produced.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to run a layer.
REQ-006 SHALL have port busy, output, 1 bit: high while a layer is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the layer is finished.
REQ-008 SHALL have port x_addr, output, clog2(LAYER1_NEURONS) bits: input index i.
REQ-009 SHALL have port w_addr, output, clog2(LAYER1_NEURONS*LAYER2_NEURONS) bits: row-major address i*LAYER2_NEURONS+j.
REQ-010 SHALL have port b_addr, output, clog2(LAYER2_NEURONS) bits: neuron index j.
REQ-011 SHALL have ports x_data, w_data and b_data, input, 16 bits each: half-precision values, combinationally valid for the current addresses.
REQ-012 SHALL have port op_valid, output, 1 bit, and port op_ready, input, 1 bit: MAC issue handshake.
REQ-013 SHALL have ports op_a, op_b and op_c, output, 16 bits each: MAC operands; the shared unit computes op_c + op_a*op_b.
REQ-014 SHALL have port res_valid, input, 1 bit, and port res_data, input, 16 bits: MAC result return.
REQ-015 SHALL have ports l_wr_en (output, 1 bit), l_wr_addr (output, clog2(LAYER2_NEURONS) bits) and l_wr_data (output, 16 bits): output write port.

Function
REQ-016 SHALL implement the states IDLE, BIAS, ISSUE, WAIT, WRITE and FINISH.
REQ-017 SHALL, in IDLE with start=1, clear i and j to 0, set busy on the next cycle, and go to BIAS.
REQ-018 SHALL, in BIAS, load acc <= b_data from b_addr=j, clear i, and go to ISSUE; this state takes 1 cycle.
REQ-019 SHALL, in ISSUE, drive op_valid=1 with op_a=x_data, op_b=w_data and op_c=acc, and go to WAIT on the cycle in which op_ready=1.
REQ-020 SHALL hold op_valid, op_a, op_b and op_c stable while op_ready=0.
REQ-021 SHALL keep op_valid low in every state other than ISSUE, so at most one operation is outstanding.
REQ-022 SHALL, in WAIT on res_valid=1, set acc <= res_data; then if i==LAYER1_NEURONS-1 go to WRITE, otherwise increment i and go to ISSUE.
REQ-023 SHALL ignore res_valid in every state other than WAIT.
REQ-024 SHALL, in WRITE, pulse l_wr_en for 1 cycle with l_wr_addr=j and l_wr_data=f(acc); then if j==LAYER2_NEURONS-1 go to FINISH, otherwise increment j and go to BIAS.
REQ-025 SHALL, in FINISH, pulse done for 1 cycle, deassert busy in the same cycle, and return to IDLE.
REQ-026 SHALL ignore start whenever the state is not IDLE; there is no queueing.
REQ-027 SHALL accept a new start in the cycle after done.
REQ-028 SHALL, with zero-latency handshakes (op_ready=1, and res_valid 1 cycle after issue), complete a layer in 1 + LAYER2_NEURONS*(2 + 2*LAYER1_NEURONS) + 1 cycles from the start edge to done.
REQ-029 SHALL perform no arithmetic itself; acc is a 16-bit register copied verbatim except as modified by REQ-034.
REQ-030 SHALL wrap no counter: i and j never exceed LAYER1_NEURONS-1 and LAYER2_NEURONS-1 respectively.

Reset
REQ-031 SHALL, when rstn=0 at a clock edge, force the state to IDLE and clear i, j and acc to 0.
REQ-032 SHALL, while in reset, drive busy=0, done=0, op_valid=0, l_wr_en=0, all address outputs to 0 and all data outputs to 0.
REQ-033 SHALL, on a reset mid-layer, abandon the layer with no further l_wr_en and no done pulse; a res_valid arriving after reset is ignored.

Configuration
REQ-034 SHALL, when macro HALF_LAYER1_RELU_EN is defined, define f(acc) as 16'h0000 if acc[15]=1 (this includes -0 = 16'h8000), and acc otherwise.
REQ-035 SHALL, when macro HALF_LAYER1_RELU_EN is undefined, define f(acc) as acc unchanged.

Verification
REQ-036 SHALL cover: LAYER1_NEURONS=2, LAYER2_NEURONS=2, b={3C00,4000}, unit returns op_c+1.0 with zero latency -> writes l[0]=4200 and l[1]=4400, done exactly at the cycle count given by REQ-028.
REQ-037 SHALL cover: op_ready held low for 5 cycles on the first issue -> op_a, op_b and op_c constant throughout, with one issue counted.
REQ-038 SHALL cover: start pulsed again while busy, and a spurious res_valid while in ISSUE -> no restart, acc unchanged, writes identical to the REQ-036 scenario.
REQ-039 SHALL cover: rstn=0 for 1 cycle while in WAIT for j=1 -> no l_wr_en and no done; all outputs 0; a subsequent start completes normally.
REQ-040 SHALL cover: res_data=C000 on the last operation with HALF_LAYER1_RELU_EN defined -> l_wr_data=0000; without the macro -> l_wr_data=C000; res_data=8000 with the macro defined -> 0000.
